mem_access_unit: RTL and testbench

Initiator-side front end for the byte-addressed data memory: accepts one load/store request at a time from the execute stage and drives the memory's write enable, size code, address and write data. It returns sign/zero-extended load data, or a store completion, as a one-cycle response. Misaligned accesses are either split into byte beats or rejected with an error, depending on build configuration. It sits between the core's execute stage and the data memory.

---
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store front end for the byte-addressed data memory.
// Build option MEM_MISALIGN_SPLIT_EN: misaligned half/word accesses run as byte beats instead of erroring.
module mem_access_unit #(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [2:0]             req_size_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [BYTE_SIZE*8-1:0] req_wdata_i,
  output logic                   resp_valid_o,
  output logic                   resp_err_o,
  output logic [BYTE_SIZE*8-1:0] resp_rdata_o,
  output logic                   mem_we_o,
  output logic [2:0]             mem_size_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [BYTE_SIZE*8-1:0] mem_wd_o,
  input  logic [BYTE_SIZE*8-1:0] mem_rd_i
);

  localparam int DW = BYTE_SIZE * 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

  state_t                state_q;
  logic                  we_q;
  logic                  req_ready_q, resp_valid_q, resp_err_q, mem_we_q;
  logic [DW-1:0]         resp_rdata_q, mem_wd_q;
  logic [2:0]            mem_size_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  size_illegal_d, misaligned_d;
  logic [2:0]            st_size_d;

  assign size_illegal_d = (req_size_i > 3'b100);

  always_comb begin
    misaligned_d = 1'b0;
    case (req_size_i)
      3'b000:         misaligned_d = (req_addr_i[1:0] != 2'b00);
      3'b001, 3'b010: misaligned_d = req_addr_i[0];
      default:        misaligned_d = 1'b0;
    endcase
  end

  // The memory only writes size codes 000/001/011; signedness is meaningless for stores.
  always_comb begin
    st_size_d = req_size_i;
    case (req_size_i)
      3'b010:  st_size_d = 3'b001;
      3'b100:  st_size_d = 3'b011;
      default: st_size_d = req_size_i;
    endcase
  end

`ifdef MEM_MISALIGN_SPLIT_EN
  logic [1:0]            beat_q, beat_nxt;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [DW-1:0]         wdata_q, rdata_q, asm_d;

  assign beat_nxt  = beat_q + 2'd1;
  assign last_beat = (size_q == 3'b000) ? (beat_q == 2'd3) : (beat_q == 2'd1);

  always_comb begin
    asm_d = rdata_q;
    asm_d[{beat_q, 3'b000} +: 8] = mem_rd_i[7:0];
  end

  function automatic logic [DW-1:0] extend(input logic [2:0] sz, input logic [DW-1:0] d);
    case (sz)
      3'b001:  return {{(DW-16){d[15]}}, d[15:0]};
      3'b010:  return {{(DW-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_size_q   <= 3'b000;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
`ifdef MEM_MISALIGN_SPLIT_EN
      beat_q       <= 2'd0;
      addr_q       <= '0;
      size_q       <= 3'b000;
      wdata_q      <= '0;
      rdata_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            if (size_illegal_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (misaligned_d) begin
`ifdef MEM_MISALIGN_SPLIT_EN
              state_q    <= S_SPLIT;
              beat_q     <= 2'd0;
              addr_q     <= req_addr_i;
              size_q     <= req_size_i;
              wdata_q    <= req_wdata_i;
              rdata_q    <= '0;
              mem_we_q   <= req_we_i;
              mem_size_q <= req_we_i ? 3'b011 : 3'b100;
              mem_addr_q <= req_addr_i;
              mem_wd_q   <= req_we_i ? DW'(req_wdata_i[7:0]) : '0;
`else
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
`endif
            end else begin
              state_q    <= S_ACCESS;
              mem_we_q   <= req_we_i;
              mem_size_q <= req_we_i ? st_size_d : req_size_i;
              mem_addr_q <= req_addr_i;
              mem_wd_q   <= req_we_i ? req_wdata_i : '0;
            end
          end
        end
        S_ACCESS: begin
          state_q      <= S_RESP;
          mem_we_q     <= 1'b0;
          mem_size_q   <= 3'b000;
          mem_addr_q   <= '0;
          mem_wd_q     <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? '0 : mem_rd_i;
        end
`ifdef MEM_MISALIGN_SPLIT_EN
        S_SPLIT: begin
          rdata_q <= asm_d;
          if (last_beat) begin
            state_q      <= S_RESP;
            mem_we_q     <= 1'b0;
            mem_size_q   <= 3'b000;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? '0 : extend(size_q, asm_d);
          end else begin
            beat_q     <= beat_nxt;
            mem_addr_q <= addr_q + ADDR_WIDTH'(beat_nxt);
            mem_wd_q   <= we_q ? DW'(wdata_q[{beat_nxt, 3'b000} +: 8]) : '0;
          end
        end
`endif
        S_RESP: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_we_o     = mem_we_q;
  assign mem_size_o   = mem_size_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wd_o     = mem_wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array memory model, reference model per request,
// monitor comparing every response (value, error flag, arrival cycle).
module tb_mem_access_unit;

`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.BYTE_SIZE(4), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
    .mem_we_o(mem_we), .mem_size_o(mem_size), .mem_addr_o(mem_addr),
    .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  // Memory aliases on the low 16 address bits; the reference mirror uses the same aliasing.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  bit          init_done = 1'b0;
  int          wr_count = 0, exp_wr = 0;
  logic [2:0]  last_wr_size = 3'b111;
  logic [31:0] last_wr_addr = '0;
  int          cyc = 0;
  int          checks = 0, failures = 0;

  typedef struct {bit err; logic [31:0] rd; int cyc;} exp_t;
  exp_t sb[$];

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) ^ (i >> 8) ^ 8'h5A);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
      init_done <= 1'b1;
    end else if (mem_we) begin
      case (mem_size)
        3'b000:  for (int i = 0; i < 4; i++) mem[16'(mem_addr + 32'(i))] <= mem_wd[8*i +: 8];
        3'b001:  for (int i = 0; i < 2; i++) mem[16'(mem_addr + 32'(i))] <= mem_wd[8*i +: 8];
        3'b011:  mem[mem_addr[15:0]] <= mem_wd[7:0];
        default: ;
      endcase
      wr_count     <= wr_count + 1;
      last_wr_size <= mem_size;
      last_wr_addr <= mem_addr;
    end
  end

  logic [15:0] ma;
  logic [31:0] mw;
  always_comb begin
    ma = mem_addr[15:0];
    mw = {mem[ma + 16'd3], mem[ma + 16'd2], mem[ma + 16'd1], mem[ma]};
    case (mem_size)
      3'b000:  mem_rd = mw;
      3'b001:  mem_rd = {{16{mw[15]}}, mw[15:0]};
      3'b010:  mem_rd = {16'h0, mw[15:0]};
      3'b011:  mem_rd = {{24{mw[7]}}, mw[7:0]};
      3'b100:  mem_rd = {24'h0, mw[7:0]};
      default: mem_rd = 32'h0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: what the access means architecturally, independent of how it is sequenced.
  function automatic void model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd,
                                output int lat, output int nwr);
    int nb;
    bit mis;
    logic [31:0] v;
    err = 1'b0; rd = 32'h0; lat = 1; nwr = 0;
    if (sz > 3'd4) begin
      err = 1'b1;
      return;
    end
    nb  = (sz == 3'd0) ? 4 : (sz <= 3'd2) ? 2 : 1;
    mis = (a % nb) != 0;
    if (mis && !SPLIT) begin
      err = 1'b1;
      return;
    end
    lat = mis ? nb + 1 : 2;
    if (we) begin
      nwr = mis ? nb : 1;
      for (int i = 0; i < nb; i++) ref_mem[16'(a + 32'(i))] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[16'(a + 32'(i))]) << (8 * i));
      case (sz)
        3'd1:    rd = (v[15] ? 32'hFFFF0000 : 32'h0) | v;
        3'd3:    rd = (v[7] ? 32'hFFFFFF00 : 32'h0) | v;
        default: rd = v;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit junk);
    int n;
    bit err;
    logic [31:0] rd;
    int lat, nwr;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      req_valid = junk ? 1'($urandom) : 1'b0;
      req_we    = 1'($urandom);
      req_size  = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("issue_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    model(we, sz, a, wd, err, rd, lat, nwr);
    e.err = err; e.rd = rd; e.cyc = cyc + lat;
    sb.push_back(e);
    exp_wr += nwr;
    @(posedge clk);
    #1;
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && req_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w0, bad;
    logic [2:0] sz;
    logic [31:0] a;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_bus", {mem_we, mem_size, mem_addr[27:0]} | mem_wd, 32'd0);
    rst = 1'b0;

    w0 = wr_count;
    issue(1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 1'b0);
    wait_idle();
    chk("st_word_we_cycles", 32'(wr_count - w0), 32'd1);
    chk("st_word_mem_size", 32'(last_wr_size), 32'd0);
    issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b0);
    wait_idle();

    issue(1'b1, 3'b011, 32'h20, 32'h00000080, 1'b0);
    issue(1'b1, 3'b100, 32'h21, 32'h123456FF, 1'b0);
    wait_idle();
    chk("st_ubyte_mem_size", 32'(last_wr_size), 32'd3);
    issue(1'b0, 3'b011, 32'h20, 32'h0, 1'b0);
    issue(1'b0, 3'b100, 32'h20, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'h20, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    wait_idle();

    w0 = wr_count;
    issue(1'b1, 3'b000, 32'h31, 32'h11223344, 1'b0);
    wait_idle();
    chk("split_st_we_cycles", 32'(wr_count - w0), SPLIT ? 32'd4 : 32'd0);
    if (SPLIT) begin
      chk("split_st_mem_size", 32'(last_wr_size), 32'd3);
      chk("split_st_last_addr", last_wr_addr, 32'h34);
    end
    issue(1'b0, 3'b000, 32'h31, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'h41, 32'h0, 1'b0);
    w0 = wr_count;
    issue(1'b1, 3'b101, 32'h60, 32'hCAFEF00D, 1'b0);
    issue(1'b0, 3'b111, 32'h60, 32'h0, 1'b0);
    wait_idle();
    chk("illegal_no_write", 32'(wr_count - w0), 32'd0);

    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000A1B2, 1'b0);
    issue(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b0);
    wait_idle();

    // Abort: reset lands on the edge that would start beat 1 (or end ACCESS without split).
    @(negedge clk);
    req_valid = 1'b1; req_we = SPLIT; req_size = 3'b000;
    req_addr  = SPLIT ? 32'h51 : 32'h50; req_wdata = 32'hA5B6C7D8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (SPLIT) begin
      ref_mem[16'h51] = 8'hD8;
      exp_wr += 1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    sb.delete();
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int k = 0; k < 300; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      issue(1'($urandom), sz, a, $urandom, 1'($urandom));
    end
    wait_idle();

    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_contents_bad_bytes", 32'(bad), 32'd0);
    chk("total_we_cycles", 32'(wr_count), 32'(exp_wr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
